// File: rtl/enfreq_ctr.sv
// enfreq_ctr: programmable-prescaler clock-enable timebase driving an up/down wrap/one-shot counter.
module enfreq_ctr #(
  parameter int DIV_W           = 5,
  parameter int DIV_DEFAULT     = 19,
  parameter int CNT_W           = 4,
  parameter int CNT_DEFAULT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic             clear,
  input  logic [CNT_W-1:0] cnt_max,
  input  logic             dir,
  input  logic             oneshot,
  output logic             tick,
  output logic [CNT_W-1:0] syscnt,
  output logic             carry,
  output logic             done
);
  logic [DIV_W-1:0] div_q, div_d, divcnt_q, divcnt_d;
  logic [CNT_W-1:0] syscnt_q, syscnt_d;
  logic             tick_q, tick_d, carry_q, carry_d, done_q, done_d;
  logic             wrap_pt, term, adv;
  assign wrap_pt = divcnt_q == div_q;
  assign adv     = tick_q && !done_q;
  // cnt_max may be lowered below syscnt while counting up, so >= rather than ==.
  assign term    = dir ? (syscnt_q == '0) : (syscnt_q >= cnt_max);
  always_comb begin
    div_d    = div_q;
    divcnt_d = run ? (wrap_pt ? '0 : divcnt_q + 1'b1) : divcnt_q;
    tick_d   = run && wrap_pt;
    syscnt_d = syscnt_q;
    carry_d  = 1'b0;
    done_d   = done_q;
    if (adv) begin
      carry_d  = term;
      done_d   = term && oneshot;
      syscnt_d = !term ? (dir ? syscnt_q - 1'b1 : syscnt_q + 1'b1)
               : (oneshot ^ dir) ? cnt_max : '0;
    end
    if (div_load) begin
      div_d    = div_val;
      divcnt_d = '0;
      tick_d   = 1'b0;
    end
    if (clear) begin
      div_d    = div_q;
      divcnt_d = '0;
      tick_d   = 1'b0;
      carry_d  = 1'b0;
      done_d   = 1'b0;
      syscnt_d = dir ? cnt_max : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_W'(DIV_DEFAULT);
      divcnt_q <= '0;
      tick_q   <= 1'b0;
      syscnt_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      divcnt_q <= divcnt_d;
      tick_q   <= tick_d;
      syscnt_q <= syscnt_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end
  assign tick   = tick_q;
  assign syscnt = syscnt_q;
  assign carry  = carry_q;
  assign done   = done_q;
endmodule

// File: doc/enfreq_ctr.md
# enfreq_ctr

Parametrised clock-enable timebase: a runtime-programmable prescaler produces a single-cycle `tick` every `div_q+1` system clocks, and a configurable counter advances only on ticks. The counter supports up/down direction, wrap or one-shot termination and a terminal-count `carry`. The block is the standard slow-timebase source for LED scanning, debounce and sample-rate logic. All logic runs on the single system clock; no derived clocks are generated.

## Interface
- `DIV_W`, 5: prescaler register width.
- `DIV_DEFAULT`, 19: divide value loaded at reset (tick period = DIV_DEFAULT+1).
- `CNT_W`, 4: counter width.
- `CNT_DEFAULT_MAX`, 15: not used for logic; bench default for `cnt_max`.

Ports:
- `clk` in 1: system clock; all state on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `run` in 1: 1 = prescaler advances; 0 = prescaler and counter hold.
- `div_load` in 1: load `div_val` into the divide register this cycle.
- `div_val` in DIV_W: new divide value.
- `clear` in 1: synchronous soft clear of the prescaler and counter.
- `cnt_max` in CNT_W: counter terminal value, sampled live.
- `dir` in 1: 0 = count up, 1 = count down.
- `oneshot` in 1: 0 = wrap at terminal; 1 = stop at terminal.
- `tick` out 1: single-cycle enable pulse.
- `syscnt` out CNT_W: counter value.
- `carry` out 1: single-cycle pulse when the counter reaches its terminal.
- `done` out 1: sticky flag, one-shot terminal reached.

## Operation
- Reset (`rst`=1, highest priority) sets: `div_q`=DIV_DEFAULT, `divcnt`=0, `tick`=0, `syscnt`=0, `carry`=0, `done`=0.
- Priority after `rst`:
  - `clear` resets `divcnt`, `tick`, `carry` and `done`. `syscnt` goes to 0 if `dir`=0, else to `cnt_max`. `div_q` is kept.
  - `div_load` sets `div_q`←`div_val` and `divcnt`←0. It is not gated by `run`. `tick` is forced to 0 in that cycle.
  - Normal operation follows.
- Prescaler, when `run`=1:
  - If `divcnt`==`div_q`, then `divcnt`←0.
  - Otherwise `divcnt`←`divcnt`+1.
  - `tick`←(`run` && `divcnt`==`div_q`) is a registered pulse, never more than one cycle wide.
  - `div_q`=0 gives `tick` high every cycle while `run`=1.
- Counter advances on each edge where `tick`=1 and `done`=0:
  - Up, `syscnt`<`cnt_max`: `syscnt`+1.
  - Up, `syscnt`>=`cnt_max`: terminal. Wrap sets `syscnt`←0; one-shot holds `syscnt`←`cnt_max`.
  - Down, `syscnt`>0: `syscnt`−1.
  - Down, `syscnt`==0: terminal. Wrap sets `syscnt`←`cnt_max`; one-shot holds 0.
  - At terminal, `carry` pulses for 1 cycle. In one-shot mode `done`←1.
  - While `done`=1, ticks are ignored: no carry, no count. Only `clear` or `rst` leaves this state.
- `dir`, `oneshot` and `cnt_max` are sampled on each tick edge. A change applies from the next tick without re-initialising `syscnt`.
- `cnt_max` lowered below `syscnt` while counting up: the next tick is terminal.
- `cnt_max`=0: every tick is terminal, `syscnt` stays 0, and `carry` follows every tick.
- All arithmetic is modulo width; no value exceeds its field.

## Timing
- Period: with `run` held at 1, `tick` is high for 1 cycle every `div_q`+1 cycles.
- First tick: the first `tick` is seen `div_q`+1 cycles after the first edge with `run`=1 following reset, clear or div_load.
- Counter latency: `syscnt` and `carry` update on the edge after `tick` is high, i.e. 1 cycle of latency.
- `run` drop:
  - `run` dropped: `divcnt` holds and `tick` is 0 on the next cycle.
  - `run` re-asserted: counting resumes from the held `divcnt` with no phase loss.
- Simultaneous events:
  - `clear` with a pending tick: clear wins and no count occurs.
  - `div_load` with a tick: the counter still consumes that tick.
  - `rst` overrides everything.
- Reset mid-operation returns all outputs to their reset values on the next edge.

## Test plan
- Defaults, `run`=1, `dir`=0, `oneshot`=0, `cnt_max`=15:
  - `tick` every 20 cycles.
  - `syscnt` 0→15→0.
  - `carry` pulses once per 320 cycles, aligned with the 15→0 transition.
- `div_load` with `div_val`=0 mid-count: `tick` high every cycle from the following cycle. `syscnt` increments each cycle after the first.
- One-shot down, `cnt_max`=3, `clear`:
  - `syscnt` goes 3,2,1,0, then `carry` pulses once and `done`=1.
  - Further ticks leave `syscnt`=0.
  - `clear` restores `syscnt`=3 and `done`=0.
- `run` toggles: drop `run` at `divcnt`=7 for 50 cycles.
  - `tick` and `syscnt` hold.
  - Next `tick` arrives 13 cycles after `run` returns.
- Simultaneous `clear` and tick, then `cnt_max` lowered from 15 to 5 with `syscnt`=9:
  - The clear yields `syscnt`=0 with no carry.
  - At `syscnt`=9 with `cnt_max` now 5, the next tick wraps `syscnt` to 0 with `carry`.
- `rst` asserted mid-count with `div_q`=7: next cycle shows `syscnt`=0, `tick`/`carry`/`done`=0, and `div_q` restored to 19.
